// File: rtl/seq_sm_mul_pkg.sv
// seq_sm_mul_pkg: shared state encoding and width helpers for the sign-magnitude multiplier
package seq_sm_mul_pkg;
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
   function automatic int mag_w(input int w);
      return w - 1;
   endfunction
   function automatic int prod_w(input int w);
      return 2 * w - 1;
   endfunction
   function automatic int cnt_w(input int w);
      return $clog2(w);
   endfunction
endpackage

// File: rtl/seq_sm_mul_dp.sv
// seq_sm_mul_dp: shift-and-add magnitude datapath, one multiplier bit per step
module seq_sm_mul_dp
   import seq_sm_mul_pkg::*;
#(
   parameter int W = 3,
   localparam int M = mag_w(W)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load,
   input  logic           step,
   input  logic [M-1:0]   mag_a_in,
   input  logic [M-1:0]   mag_b_in,
   output logic [2*M-1:0] acc_nxt,
   output logic           b_last
);
   logic [2*M-1:0] mag_a, mag_b, acc;
   // accumulator value after the current step, and whether the multiplier runs out of ones
   always_comb begin
      acc_nxt = acc + (mag_b[0] ? mag_a : '0);
      b_last  = (mag_b >> 1) == '0;
   end
   // operand capture on load, then add-and-shift on every step
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mag_a <= '0;
         mag_b <= '0;
         acc   <= '0;
      end else if (load) begin
         mag_a <= (2*M)'(mag_a_in);
         mag_b <= (2*M)'(mag_b_in);
         acc   <= '0;
      end else if (step) begin
         acc   <= acc_nxt;
         mag_a <= mag_a << 1;
         mag_b <= mag_b >> 1;
      end
   end
endmodule

// File: rtl/seq_sm_mul.sv
// seq_sm_mul: sequential sign-magnitude multiplier with start/busy/done handshake (optional SEQ_SM_MUL_EARLY_TERM_EN)
module seq_sm_mul
   import seq_sm_mul_pkg::*;
#(
   parameter int W = 3,
   localparam int PW = prod_w(W)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   output logic          busy,
   output logic          done,
   output logic [PW-1:0] p
);
   localparam int M  = mag_w(W);
   localparam int CW = cnt_w(W);
`ifdef SEQ_SM_MUL_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif
   state_t         state, state_nxt;
   logic [CW-1:0]  cnt;
   logic           sign, load, step, fin, b_last;
   logic [2*M-1:0] acc_nxt;
   seq_sm_mul_dp #(.W(W)) u_dp (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .step     (step),
      .mag_a_in (a[W-2:0]),
      .mag_b_in (b[W-2:0]),
      .acc_nxt  (acc_nxt),
      .b_last   (b_last)
   );
   // control decode: accept start whenever not running, finish when bits are exhausted
   always_comb begin
      load      = start && state != RUN;
      step      = state == RUN;
      fin       = step && (cnt == CW'(1) || (EARLY && b_last));
      state_nxt = load ? RUN : fin ? FIN : state;
      busy      = step;
   end
   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end
   // bit counter, sign, and result register; zero magnitude always yields a positive sign
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         sign <= 1'b0;
         done <= 1'b0;
         p    <= '0;
      end else begin
         done <= fin;
         if (load) begin
            cnt  <= CW'(M);
            sign <= a[W-1] ^ b[W-1];
         end else if (step) begin
            cnt  <= cnt - CW'(1);
         end
         if (fin) p <= {sign & (|acc_nxt), acc_nxt};
      end
   end
endmodule

// File: tb/tb_seq_sm_mul.sv
// tb_seq_sm_mul: scoreboard bench for W=3 and W=8 instances of seq_sm_mul
module tb_seq_sm_mul;
   typedef struct {logic [14:0] p; int c;} exp_t;
   logic        clk = 0, rst = 1;
   logic        start3 = 0, start8 = 0;
   logic [2:0]  a3 = 0, b3 = 0;
   logic [7:0]  a8 = 0, b8 = 0;
   logic        busy3, done3, busy8, done8;
   logic [4:0]  p3;
   logic [14:0] p8;
   int          total = 0, bad = 0, cyc = 0;
   exp_t        q3[$], q8[$];

   seq_sm_mul #(.W(3)) u3 (.clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3),
                           .busy(busy3), .done(done3), .p(p3));
   seq_sm_mul #(.W(8)) u8 (.clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
                           .busy(busy8), .done(done8), .p(p8));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // edges from the start-sampling edge (inclusive) to the edge raising done
   function automatic int lat(input int m, input logic [13:0] mb);
      int hb;
      hb = -1;
      for (int i = 0; i < 14; i++) if (mb[i]) hb = i;
`ifdef SEQ_SM_MUL_EARLY_TERM_EN
      return 1 + ((hb + 1) > 1 ? hb + 1 : 1);
`else
      return m + 1;
`endif
   endfunction

   // caller is at a negedge; returns one negedge later with start dropped
   task automatic drive3(input logic [2:0] x, y, input logic [4:0] e);
      a3 = x; b3 = y; start3 = 1;
      q3.push_back('{15'(e), cyc + lat(2, 14'(y[1:0]))});
      @(negedge clk);
      start3 = 0;
   endtask

   task automatic drive8(input logic [7:0] x, y, input logic [14:0] e, input bit push);
      a8 = x; b8 = y; start8 = 1;
      if (push) q8.push_back('{e, cyc + lat(7, 14'(y[6:0]))});
      @(negedge clk);
      start8 = 0;
   endtask

   task automatic wait_done8(input string name);
      for (int i = 0; i < 40; i++) begin
         if (done8) return;
         @(negedge clk);
      end
      chk({name, " timeout"}, 0, 1);
   endtask

   task automatic wait_done3(input string name);
      for (int i = 0; i < 40; i++) begin
         if (done3) return;
         @(negedge clk);
      end
      chk({name, " timeout"}, 0, 1);
   endtask

   // monitor: every done pulse must match the oldest outstanding expectation, value and cycle
   always @(negedge clk) begin
      exp_t e;
      if (done3) begin
         if (q3.size() == 0) chk("u3 unexpected done", 1, 0);
         else begin
            e = q3.pop_front();
            chk("u3 p", 32'(p3), 32'(e.p));
            chk("u3 done cycle", cyc, e.c);
         end
      end
      if (done8) begin
         if (q8.size() == 0) chk("u8 unexpected done", 1, 0);
         else begin
            e = q8.pop_front();
            chk("u8 p", 32'(p8), 32'(e.p));
            chk("u8 done cycle", cyc, e.c);
         end
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst busy3", busy3, 0);
      chk("rst done3", done3, 0);
      chk("rst p3", 32'(p3), 0);
      chk("rst busy8", busy8, 0);
      chk("rst p8", 32'(p8), 0);
      rst = 0;
      @(negedge clk);
      // +3 * -3 = -9, busy for exactly two cycles
      drive3(3'b011, 3'b111, 5'b11001);
      chk("busy3 c1", busy3, 1);
      @(negedge clk);
      chk("busy3 c2", busy3, 1);
      @(negedge clk);
      chk("busy3 c3", busy3, 0);
      chk("done3 c3", done3, 1);
      @(negedge clk);
      chk("done3 one cycle", done3, 0);
      chk("p3 held", 32'(p3), 32'(5'b11001));
      drive3(3'b100, 3'b110, 5'b00000);
      wait_done3("t2");
      @(negedge clk);
      drive3(3'b111, 3'b011, 5'b11001);
      wait_done3("t2b");
      @(negedge clk);
      drive3(3'b010, 3'b001, 5'b00010);
      wait_done3("t2c");
      @(negedge clk);
      // full-scale W=8
      drive8(8'h7F, 8'hFF, 15'h7F01, 1);
      wait_done8("t3");
      @(negedge clk);
      // back-to-back: second start held in the done cycle
      drive8(8'h83, 8'h04, 15'h400C, 1);
      wait_done8("t4a");
      drive8(8'h05, 8'h06, 15'd30, 1);
      wait_done8("t4b");
      @(negedge clk);
      // start pulse mid-run with different operands is ignored
      drive8(8'h0A, 8'h0B, 15'd110, 1);
      a8 = 8'hFF; b8 = 8'hFF; start8 = 1;
      @(negedge clk);
      start8 = 0;
      wait_done8("t4c");
      @(negedge clk);
      // async reset during the fourth RUN cycle
      drive8(8'h12, 8'h13, 15'd0, 0);
      repeat (3) @(negedge clk);
      chk("busy8 before rst", busy8, 1);
      chk("p8 before rst", 32'(p8), 110);
      #1 rst = 1;
      #1;
      chk("rst busy8 async", busy8, 0);
      chk("rst done8 async", done8, 0);
      chk("rst p8 async", 32'(p8), 0);
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      drive8(8'h12, 8'h93, 15'h4156, 1);
      wait_done8("t5");
      @(negedge clk);
      // single-bit multiplier (early-termination candidate)
      drive8(8'h05, 8'h01, 15'd5, 1);
      wait_done8("t6");
      @(negedge clk);
      // zero multiplier, negative operands
      drive8(8'h85, 8'h80, 15'd0, 1);
      wait_done8("t6b");
      repeat (4) @(negedge clk);
      chk("q3 drained", q3.size(), 0);
      chk("q8 drained", q8.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
